// File: rtl/axis_step_counter.sv
// axis_step_counter: AXI4-Stream arithmetic sequence generator.
// Emits frames of cfg_length beats running start, start+step, ... and stops
// after cfg_frames frames (0 = endless) or after a dropped run request lets
// the current frame finish.
// Optional feature macro: AXIS_STEP_COUNTER_TLAST_EN adds the m_axis_tlast port.
module axis_step_counter #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int FRAME_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_start,
    input  logic [CNTR_WIDTH-1:0]       cfg_step,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic [FRAME_WIDTH-1:0]      cfg_frames,
    input  logic                        cfg_run,
    output logic                        sts_busy,
    output logic [FRAME_WIDTH-1:0]      sts_frames,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
`ifdef AXIS_STEP_COUNTER_TLAST_EN
    output logic                        m_axis_tlast,
`endif
    input  logic                        m_axis_tready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CNTR_WIDTH-1:0]  value;
    logic [CNTR_WIDTH-1:0]  idx;
    logic [CNTR_WIDTH-1:0]  sh_start;
    logic [CNTR_WIDTH-1:0]  sh_step;
    logic [CNTR_WIDTH-1:0]  sh_len;
    logic [FRAME_WIDTH-1:0] sh_frames;
    logic [FRAME_WIDTH-1:0] frames_cnt;
    logic                   stop_pend;
    logic                   tvalid;
    logic                   busy;

    // Shadow length is never zero in RUN, so len_m1 is the true last index.
    logic [CNTR_WIDTH-1:0]  len_m1;
    logic [CNTR_WIDTH-1:0]  idx_inc;
    logic [FRAME_WIDTH-1:0] frames_inc;
    logic                   is_last;
    logic                   hs;
    logic                   finish;

    assign len_m1     = sh_len - CNTR_WIDTH'(1);
    assign idx_inc    = idx + CNTR_WIDTH'(1);
    assign frames_inc = frames_cnt + FRAME_WIDTH'(1);
    assign is_last    = (idx == len_m1);
    assign hs         = tvalid & m_axis_tready;
    // A run request dropping on the very edge of the final beat still stops
    // the block there rather than starting one more frame.
    assign finish     = ((sh_frames != '0) && (frames_inc == sh_frames))
                        || stop_pend || !cfg_run;

    assign m_axis_tdata  = AXIS_TDATA_WIDTH'(value);
    assign m_axis_tvalid = tvalid;
    assign sts_busy      = busy;
    assign sts_frames    = frames_cnt;

`ifdef AXIS_STEP_COUNTER_TLAST_EN
    logic tlast;
    assign m_axis_tlast = tlast;

    // tlast is registered alongside the beat it marks, so it tracks the next index.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tlast <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_run && cfg_length != '0)
                        tlast <= (cfg_length == CNTR_WIDTH'(1));
                    else
                        tlast <= 1'b0;
                end
                S_RUN: begin
                    if (hs) begin
                        if (is_last)
                            tlast <= finish ? 1'b0 : (len_m1 == '0);
                        else
                            tlast <= (idx_inc == len_m1);
                    end
                end
                default: tlast <= 1'b0;
            endcase
        end
    end
`endif

    // Main control FSM: start on run request, step value per handshake,
    // count frames and decide between another frame and DONE.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            value      <= '0;
            idx        <= '0;
            sh_start   <= '0;
            sh_step    <= '0;
            sh_len     <= '0;
            sh_frames  <= '0;
            frames_cnt <= '0;
            stop_pend  <= 1'b0;
            tvalid     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tvalid <= 1'b0;
                    busy   <= 1'b0;
                    if (cfg_run && cfg_length != '0) begin
                        sh_start   <= cfg_start;
                        sh_step    <= cfg_step;
                        sh_len     <= cfg_length;
                        sh_frames  <= cfg_frames;
                        value      <= cfg_start;
                        idx        <= '0;
                        frames_cnt <= '0;
                        stop_pend  <= 1'b0;
                        tvalid     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!cfg_run)
                        stop_pend <= 1'b1;
                    if (hs) begin
                        if (is_last) begin
                            frames_cnt <= frames_inc;
                            value      <= sh_start;
                            idx        <= '0;
                            if (finish) begin
                                tvalid <= 1'b0;
                                busy   <= 1'b0;
                                state  <= S_DONE;
                            end
                        end else begin
                            value <= value + sh_step;
                            idx   <= idx_inc;
                        end
                    end
                end
                S_DONE: begin
                    tvalid <= 1'b0;
                    busy   <= 1'b0;
                    if (!cfg_run)
                        state <= S_IDLE;
                end
                default: begin
                    tvalid <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_step_counter.sv
// Testbench for axis_step_counter: vector table for frame/backpressure/length
// cases plus hand sequences for wrap, endless-stop and mid-frame reset.
module tb_axis_step_counter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_start, cfg_step, cfg_length;
    logic [15:0] cfg_frames;
    logic        cfg_run;
    logic        sts_busy;
    logic [15:0] sts_frames;
    logic [31:0] tdata;
    logic        tvalid, tready, tlast;

    logic [7:0]  w_start, w_step, w_len;
    logic [15:0] w_frames;
    logic        w_run, w_busy;
    logic [15:0] w_sfr;
    logic [15:0] w_tdata;
    logic        w_tvalid, w_tready, w_tlast;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axis_step_counter dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_start     (cfg_start),
        .cfg_step      (cfg_step),
        .cfg_length    (cfg_length),
        .cfg_frames    (cfg_frames),
        .cfg_run       (cfg_run),
        .sts_busy      (sts_busy),
        .sts_frames    (sts_frames),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
`ifdef AXIS_STEP_COUNTER_TLAST_EN
        .m_axis_tlast  (tlast),
`endif
        .m_axis_tready (tready)
    );

    axis_step_counter #(
        .AXIS_TDATA_WIDTH (16),
        .CNTR_WIDTH       (8),
        .FRAME_WIDTH      (16)
    ) dut8 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_start     (w_start),
        .cfg_step      (w_step),
        .cfg_length    (w_len),
        .cfg_frames    (w_frames),
        .cfg_run       (w_run),
        .sts_busy      (w_busy),
        .sts_frames    (w_sfr),
        .m_axis_tdata  (w_tdata),
        .m_axis_tvalid (w_tvalid),
`ifdef AXIS_STEP_COUNTER_TLAST_EN
        .m_axis_tlast  (w_tlast),
`endif
        .m_axis_tready (w_tready)
    );

`ifndef AXIS_STEP_COUNTER_TLAST_EN
    assign tlast   = 1'b0;
    assign w_tlast = 1'b0;
`endif

    typedef struct {
        logic [31:0] start, step, len;
        logic [15:0] frames;
        logic        run, rdy;
        logic        v;
        logic [31:0] d;
        logic        last, busy;
        logic [15:0] frm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] ln,
                       input logic [15:0] fr, input logic r, input logic rd,
                       input logic v, input logic [31:0] d, input logic l,
                       input logic b, input logic [15:0] f);
        vec_t x;
        x.start = st; x.step = sp; x.len = ln; x.frames = fr;
        x.run = r; x.rdy = rd; x.v = v; x.d = d; x.last = l; x.busy = b; x.frm = f;
        vecs.push_back(x);
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_last(input string nm, input logic act, input logic exp);
`ifdef AXIS_STEP_COUNTER_TLAST_EN
        chk(nm, {31'd0, act}, {31'd0, exp});
`endif
    endtask

    initial begin
        // Basic frames: 10,13,16,19 x2; config garbled mid-run must be ignored.
        add(10, 3, 4, 2, 1, 1,  1, 10, 0, 1, 0);
        add(10, 3, 4, 2, 1, 1,  1, 13, 0, 1, 0);
        add(99, 7, 9, 0, 1, 1,  1, 16, 0, 1, 0);
        add(99, 7, 9, 0, 1, 1,  1, 19, 1, 1, 0);
        add(99, 7, 9, 0, 1, 1,  1, 10, 0, 1, 1);
        add(99, 7, 9, 0, 1, 1,  1, 13, 0, 1, 1);
        add(99, 7, 9, 0, 1, 1,  1, 16, 0, 1, 1);
        add(99, 7, 9, 0, 1, 1,  1, 19, 1, 1, 1);
        add(99, 7, 9, 0, 1, 1,  0,  0, 0, 0, 2);
        add(99, 7, 9, 0, 0, 1,  0,  0, 0, 0, 2);
        // Backpressure: 0..4 with stalls, held run must not retrigger in DONE.
        add(0, 1, 5, 1, 1, 1,  1, 0, 0, 1, 0);
        add(0, 1, 5, 1, 1, 1,  1, 1, 0, 1, 0);
        add(0, 1, 5, 1, 1, 0,  1, 1, 0, 1, 0);
        add(0, 1, 5, 1, 1, 0,  1, 1, 0, 1, 0);
        add(0, 1, 5, 1, 1, 1,  1, 2, 0, 1, 0);
        add(0, 1, 5, 1, 1, 1,  1, 3, 0, 1, 0);
        add(0, 1, 5, 1, 1, 0,  1, 3, 0, 1, 0);
        add(0, 1, 5, 1, 1, 0,  1, 3, 0, 1, 0);
        add(0, 1, 5, 1, 1, 1,  1, 4, 1, 1, 0);
        add(0, 1, 5, 1, 1, 0,  1, 4, 1, 1, 0);
        add(0, 1, 5, 1, 1, 1,  0, 0, 0, 0, 1);
        add(0, 1, 5, 1, 1, 1,  0, 0, 0, 0, 1);
        add(0, 1, 5, 1, 0, 1,  0, 0, 0, 0, 1);
        // length = 1: every beat is last and equals start.
        add(42, 9, 1, 3, 1, 1,  1, 42, 1, 1, 0);
        add(42, 9, 1, 3, 1, 1,  1, 42, 1, 1, 1);
        add(42, 9, 1, 3, 1, 1,  1, 42, 1, 1, 2);
        add(42, 9, 1, 3, 1, 1,  0,  0, 0, 0, 3);
        add(42, 9, 1, 3, 0, 1,  0,  0, 0, 0, 3);
        // length = 0: never starts.
        add(7, 1, 0, 1, 1, 1,  0, 0, 0, 0, 3);
        add(7, 1, 0, 1, 1, 1,  0, 0, 0, 0, 3);
        add(7, 1, 0, 1, 0, 1,  0, 0, 0, 0, 3);

        aresetn = 1'b0;
        cfg_start = '0; cfg_step = '0; cfg_length = '0; cfg_frames = '0;
        cfg_run = 1'b0; tready = 1'b1;
        w_start = '0; w_step = '0; w_len = '0; w_frames = '0;
        w_run = 1'b0; w_tready = 1'b1;
        tick;
        tick;
        chk("reset_tvalid", {31'd0, tvalid}, 0);
        chk("reset_tdata", tdata, 0);
        chk("reset_busy", {31'd0, sts_busy}, 0);
        chk("reset_frames", {16'd0, sts_frames}, 0);
        chk_last("reset_tlast", tlast, 1'b0);
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            cfg_start  = vecs[i].start;
            cfg_step   = vecs[i].step;
            cfg_length = vecs[i].len;
            cfg_frames = vecs[i].frames;
            cfg_run    = vecs[i].run;
            tready     = vecs[i].rdy;
            tick;
            chk($sformatf("vec%0d_tvalid", i), {31'd0, tvalid}, {31'd0, vecs[i].v});
            chk($sformatf("vec%0d_busy", i), {31'd0, sts_busy}, {31'd0, vecs[i].busy});
            chk($sformatf("vec%0d_frames", i), {16'd0, sts_frames}, {16'd0, vecs[i].frm});
            if (vecs[i].v)
                chk($sformatf("vec%0d_tdata", i), tdata, vecs[i].d);
            chk_last($sformatf("vec%0d_tlast", i), tlast, vecs[i].last);
        end

        // Wrap at 8 bits: 250, 254, 2 (upper tdata bits zero).
        w_start = 8'd250; w_step = 8'd4; w_len = 8'd3; w_frames = 16'd1; w_run = 1'b1;
        tick;
        chk("wrap_v0", {31'd0, w_tvalid}, 1);
        chk("wrap_d0", {16'd0, w_tdata}, 250);
        tick;
        chk("wrap_d1", {16'd0, w_tdata}, 254);
        tick;
        chk("wrap_d2", {16'd0, w_tdata}, 2);
        chk_last("wrap_last2", w_tlast, 1'b1);
        tick;
        chk("wrap_done_v", {31'd0, w_tvalid}, 0);
        chk("wrap_done_busy", {31'd0, w_busy}, 0);
        chk("wrap_done_frames", {16'd0, w_sfr}, 1);
        w_run = 1'b0;

        // Endless run, stop requested during the second beat of frame 5.
        cfg_start = 5; cfg_step = 1; cfg_length = 3; cfg_frames = 0;
        cfg_run = 1'b1; tready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick;
            chk($sformatf("endless_c%0d_v", c), {31'd0, tvalid}, 1);
            chk($sformatf("endless_c%0d_d", c), tdata, 32'(5 + ((c - 1) % 3)));
            if ((c - 1) % 3 == 0)
                chk($sformatf("endless_c%0d_frames", c), {16'd0, sts_frames}, 32'((c - 1) / 3));
        end
        cfg_run = 1'b0;
        tick;
        chk("stop_last_d", tdata, 7);
        chk("stop_last_v", {31'd0, tvalid}, 1);
        tick;
        chk("stop_done_v", {31'd0, tvalid}, 0);
        chk("stop_done_busy", {31'd0, sts_busy}, 0);
        chk("stop_done_frames", {16'd0, sts_frames}, 5);
        tick;
        chk("stop_idle_v", {31'd0, tvalid}, 0);
        chk("stop_idle_frames", {16'd0, sts_frames}, 5);
        cfg_run = 1'b1;
        tick;
        chk("restart_v", {31'd0, tvalid}, 1);
        chk("restart_d", tdata, 5);
        chk("restart_frames", {16'd0, sts_frames}, 0);
        tick;
        chk("pre_reset_d", tdata, 6);

        // Reset mid-frame, then restart with run held high.
        aresetn = 1'b0;
        tick;
        chk("midrst_v", {31'd0, tvalid}, 0);
        chk("midrst_d", tdata, 0);
        chk("midrst_busy", {31'd0, sts_busy}, 0);
        chk("midrst_frames", {16'd0, sts_frames}, 0);
        chk_last("midrst_tlast", tlast, 1'b0);
        aresetn = 1'b1;
        tick;
        chk("postrst_v", {31'd0, tvalid}, 1);
        chk("postrst_d", tdata, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
